// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with a first-word-fall-through receive
//               FIFO and sticky frame/overrun error flags.
//   Ports:
//     clk        rising-edge clock for all state
//     rst_n      asynchronous active-low reset
//     rx         serial line, idle high, LSB first
//     rd_en      pop request from the host
//     dout       FIFO head byte; last popped value (or 0) when empty
//     rd_rdy     FIFO non-empty
//     frame_err  sticky stop-bit error flag
//     overrun    sticky FIFO-full drop flag
//     clr_err    clears frame_err and overrun
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rd_rdy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    localparam int c_tmr_w  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_occ_w  = c_ptr_w + 1;
    localparam logic [c_tmr_w-1:0] c_half_tc = c_tmr_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_tmr_w-1:0] c_bit_tc  = c_tmr_w'(CLKS_PER_BIT - 1);
    localparam logic [c_occ_w-1:0] c_full    = c_occ_w'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx};
    end
    assign w_rxs = r_sync[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t             r_state, w_state_nxt;
    logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               w_push_req;
    logic               w_stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // The timer counts from 0 in the first cycle after a state entry or a
    // sample, so the first sample lands at half a bit and every later one a
    // full bit after the previous. It is reset on every sample, so it never
    // runs past CLKS_PER_BIT-1.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push_req    = 1'b0;
        w_stop_bad    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (!w_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_timer == c_half_tc) begin
                    w_timer_nxt   = '0;
                    w_bit_idx_nxt = '0;
                    // A line back high by mid-start-bit is treated as noise.
                    w_state_nxt   = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_timer == c_bit_tc) begin
                    w_timer_nxt   = '0;
                    w_shift_nxt   = {w_rxs, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_timer == c_bit_tc) begin
                    w_timer_nxt = '0;
                    if (w_rxs) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                // Stay here while the line is held low (break) so a low
                // line is never mistaken for a new start bit.
                w_timer_nxt = '0;
                if (w_rxs) w_state_nxt = S_IDLE;
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_occ_w-1:0] r_count;
    logic [7:0]         r_last;
    logic               w_empty, w_full, w_pop, w_push, w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full);
    assign w_pop   = rd_en & ~w_empty;
    // A simultaneous pop frees the slot the push needs, so a full FIFO
    // still accepts the byte in that case.
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout   = w_empty ? r_last : r_mem[r_rd_ptr];
    assign rd_rdy = ~w_empty;

    // ------------------------------------------------------------------
    // Sticky error flags: a set event in the clearing cycle wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_stop_bad)   frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (w_drop)       overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
